ysyx_25040118_ifu: RTL and testbench

//  Instruction fetch unit for the multi-cycle NPC core. Owns the PC register, issues one instruction read
//  at a time on the imem request/response interface, and hands {pc, inst, fault} to the IDU over valid/ready.

---
 rtl/ysyx_25040118_ifu_pkg.sv | 24 ++
 rtl/ysyx_25040118_ifu_lib.sv | 44 ++++
 rtl/ysyx_25040118_ifu.sv | 131 +++++++++++++
 tb/tb_ysyx_25040118_ifu.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040118_ifu_pkg.sv
// Shared IFU definitions: widths, reset PC,
// FSM state encoding and the PC alignment check.
package ysyx_25040118_ifu_pkg;

  localparam int DEF_PC_WIDTH   = 32;
  localparam int DEF_INST_WIDTH = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_EXEC = 3'd4
  } state_t;

  localparam int STATE_W = 3;

  // Instructions are word aligned; any low bit set is a fault.
  function automatic logic misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_25040118_ifu_lib.sv
// Generic building blocks: enabled register with
// synchronous reset and a keyed mux with default.
module ysyx_25040118_Reg #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  output logic [WIDTH-1:0] dout
);

  // Load din when enabled; reset wins.
  always_ff @(posedge clk) begin
    if (rst) dout <= RESET_VAL;
    else if (wen) dout <= din;
  end

endmodule

module ysyx_25040118_MuxKeyWithDefault #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic [KEY_LEN-1:0]                    key,
  input  logic [DATA_LEN-1:0]                   default_out,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut,
  output logic [DATA_LEN-1:0]                   out
);

  localparam int PAIR = KEY_LEN + DATA_LEN;

  // Each lut entry is {key, data}; unmatched keys yield default.
  always_comb begin
    out = default_out;
    for (int i = 0; i < NR_KEY; i++) begin
      if (lut[i*PAIR+DATA_LEN +: KEY_LEN] == key)
        out = lut[i*PAIR +: DATA_LEN];
    end
  end

endmodule

// File: rtl/ysyx_25040118_ifu.sv
// Instruction fetch unit: one fetch in flight,
// PC advanced only by the next_pc handoff.
import ysyx_25040118_ifu_pkg::*;

module ysyx_25040118_ifu #(
  parameter int PC_WIDTH   = DEF_PC_WIDTH,
  parameter int INST_WIDTH = DEF_INST_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  input  logic                  imem_resp_err,
  output logic                  idu_valid,
  input  logic                  idu_ready,
  output logic [PC_WIDTH-1:0]   idu_pc,
  output logic [INST_WIDTH-1:0] idu_inst,
  output logic                  idu_fault,
  input  logic                  next_pc_valid,
  input  logic [PC_WIDTH-1:0]   next_pc
);

  state_t state, state_nx;
  state_t idle_nx, req_nx, wait_nx;
  state_t out_nx, exec_nx;

  logic [PC_WIDTH-1:0]   pc;
  logic [INST_WIDTH-1:0] inst;
  logic [INST_WIDTH-1:0] inst_din;
  logic                  fault;
  logic                  fault_din;
  logic                  mis;
  logic                  pc_wen;
  logic                  fill_mis;
  logic                  resp_take;
  logic                  cap_wen;
  logic [STATE_W-1:0]    nx_raw;
  logic [5*2*STATE_W-1:0] lut;

  assign mis       = misaligned(pc[1:0]);
  assign pc_wen    = (state == S_EXEC) && next_pc_valid;
  assign fill_mis  = (state == S_REQ) && mis;
  assign resp_take = (state == S_WAIT) && imem_resp_valid;
  assign cap_wen   = fill_mis || resp_take;
  assign inst_din  = resp_take ? imem_resp_data : '0;
  assign fault_din = resp_take ? imem_resp_err : 1'b1;

  ysyx_25040118_Reg #(
    .WIDTH(PC_WIDTH),
    .RESET_VAL(RESET_PC)
  ) u_pc (
    .clk(clk),
    .rst(rst),
    .din(next_pc),
    .wen(pc_wen),
    .dout(pc)
  );

  ysyx_25040118_Reg #(
    .WIDTH(INST_WIDTH),
    .RESET_VAL('0)
  ) u_inst (
    .clk(clk),
    .rst(rst),
    .din(inst_din),
    .wen(cap_wen),
    .dout(inst)
  );

  ysyx_25040118_Reg #(
    .WIDTH(1),
    .RESET_VAL(1'b0)
  ) u_fault (
    .clk(clk),
    .rst(rst),
    .din(fault_din),
    .wen(cap_wen),
    .dout(fault)
  );

  // Per-state successor, selected by the keyed mux below.
  always_comb begin
    idle_nx = S_REQ;
    req_nx  = S_REQ;
    wait_nx = S_WAIT;
    out_nx  = S_OUT;
    exec_nx = S_EXEC;
    if (mis) req_nx = S_OUT;
    else if (imem_req_ready) req_nx = S_WAIT;
    if (imem_resp_valid) wait_nx = S_OUT;
    if (idu_ready) out_nx = S_EXEC;
    if (next_pc_valid) exec_nx = S_REQ;
  end

  assign lut = {S_IDLE, idle_nx,
                S_REQ,  req_nx,
                S_WAIT, wait_nx,
                S_OUT,  out_nx,
                S_EXEC, exec_nx};

  ysyx_25040118_MuxKeyWithDefault #(
    .NR_KEY(5),
    .KEY_LEN(STATE_W),
    .DATA_LEN(STATE_W)
  ) u_nx (
    .key(state),
    .default_out(S_IDLE),
    .lut(lut),
    .out(nx_raw)
  );

  assign state_nx = state_t'(nx_raw);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  end

  assign imem_req_valid = (state == S_REQ) && !mis;
  assign imem_req_addr  = pc;
  assign idu_valid      = (state == S_OUT);
  assign idu_pc         = pc;
  assign idu_inst       = inst;
  assign idu_fault      = fault;

endmodule

// File: tb/tb_ysyx_25040118_ifu.sv
// Scoreboard bench for the IFU: directed fetches
// against a small memory model.
module tb_ysyx_25040118_ifu;

  localparam logic [31:0] RPC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        idu_valid;
  logic        idu_ready;
  logic [31:0] idu_pc;
  logic [31:0] idu_inst;
  logic        idu_fault;
  logic        next_pc_valid;
  logic [31:0] next_pc;

  int total = 0;
  int bad = 0;

  xfer_t       exp_q[$];
  logic [31:0] req_q[$];
  xfer_t       e;
  logic [31:0] ea;

  int          stall_left = 0;
  int          resp_delay = 1;
  int          resp_cnt = 0;
  logic [31:0] err_addr = 32'h0;
  logic [31:0] mem_addr = 32'h0;

  always #5 clk = ~clk;

  ysyx_25040118_ifu dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .idu_valid(idu_valid),
    .idu_ready(idu_ready),
    .idu_pc(idu_pc),
    .idu_inst(idu_inst),
    .idu_fault(idu_fault),
    .next_pc_valid(next_pc_valid),
    .next_pc(next_pc)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a - RPC) ^ 32'h0000_0413;
  endfunction

  task automatic chk(input string name,
                     input logic [95:0] act,
                     input logic [95:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] pc,
                      input logic [31:0] inst,
                      input logic fault,
                      input logic do_req);
    exp_q.push_back('{pc: pc, inst: inst, fault: fault});
    if (do_req) req_q.push_back(pc);
  endtask

  task automatic pulse(input logic [31:0] npc);
    @(posedge clk);
    #1;
    next_pc = npc;
    next_pc_valid = 1'b1;
    @(posedge clk);
    #1;
    next_pc_valid = 1'b0;
  endtask

  task automatic wait_hs(input string name);
    bit hit = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (idu_valid && idu_ready) begin
        hit = 1;
        break;
      end
    end
    if (!hit) chk({name, "_timeout"}, 96'(0), 96'(1));
  endtask

  // Memory model: optional ready stall, response delay,
  // error on one chosen address.
  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    imem_resp_err   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      imem_resp_valid = 1'b0;
      if (rst) begin
        imem_req_ready = 1'b0;
        resp_cnt = 0;
      end else begin
        if (imem_req_ready) begin
          imem_req_ready = 1'b0;
          resp_cnt = resp_delay;
        end else if (imem_req_valid) begin
          if (stall_left > 0) stall_left--;
          else begin
            imem_req_ready = 1'b1;
            mem_addr = imem_req_addr;
          end
        end
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_err = (mem_addr == err_addr);
            imem_resp_data = (mem_addr == err_addr) ?
              32'hFFFF_FFFF : mem_data(mem_addr);
          end
        end
      end
    end
  end

  // Monitor: pops expected requests and deliveries.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req_valid && imem_req_ready) begin
        if (req_q.size() == 0)
          chk("req_unexpected", 96'(imem_req_addr), 96'(0));
        else begin
          ea = req_q.pop_front();
          chk("req_addr", 96'(imem_req_addr), 96'(ea));
        end
      end
      if (idu_valid && idu_ready) begin
        if (exp_q.size() == 0)
          chk("idu_unexpected", 96'(idu_pc), 96'(0));
        else begin
          e = exp_q.pop_front();
          chk("idu_xfer", 96'({idu_pc, idu_inst, idu_fault}), 96'(e));
        end
      end
    end
  end

  initial begin
    int req_c;
    int val_c;
    bit hit;
    rst = 1'b1;
    idu_ready = 1'b1;
    next_pc_valid = 1'b0;
    next_pc = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs",
        96'({imem_req_valid, idu_valid, imem_req_addr,
             idu_pc, idu_inst, idu_fault}),
        96'({1'b0, 1'b0, RPC, RPC, 32'h0, 1'b0}));

    push(RPC, 32'h0000_0413, 1'b0, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    req_c = -1;
    val_c = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (imem_req_valid && req_c < 0) req_c = n;
      if (idu_valid) begin
        val_c = n;
        break;
      end
    end
    chk("t1_latency", 96'(val_c - req_c), 96'(2));

    push(RPC + 32'h4, 32'h0000_0417, 1'b0, 1'b1);
    pulse(RPC + 32'h4);
    idu_ready = 1'b0;
    hit = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (idu_valid) begin
        hit = 1;
        break;
      end
    end
    if (!hit) chk("t2_timeout", 96'(0), 96'(1));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t2_hold",
          96'({idu_valid, idu_pc, idu_inst, idu_fault, imem_req_valid}),
          96'({1'b1, RPC + 32'h4, 32'h0000_0417, 1'b0, 1'b0}));
    end
    @(posedge clk);
    #1 idu_ready = 1'b1;
    wait_hs("t2_hs");

    stall_left = 3;
    push(RPC + 32'h8, 32'h0000_041B, 1'b0, 1'b1);
    pulse(RPC + 32'h8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_req_hold", 96'({imem_req_valid, imem_req_addr}),
          96'({1'b1, RPC + 32'h8}));
    end
    wait_hs("t3_hs");

    push(RPC + 32'h6, 32'h0, 1'b1, 1'b0);
    pulse(RPC + 32'h6);
    @(negedge clk);
    chk("t4_no_req", 96'(imem_req_valid), 96'(0));
    wait_hs("t4_hs");

    err_addr = RPC + 32'h10;
    push(RPC + 32'h10, 32'hFFFF_FFFF, 1'b1, 1'b1);
    pulse(RPC + 32'h10);
    wait_hs("t5_hs");
    err_addr = 32'h0;

    resp_delay = 4;
    req_q.push_back(RPC + 32'h14);
    pulse(RPC + 32'h14);
    hit = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        hit = 1;
        break;
      end
    end
    if (!hit) chk("t6_accept_timeout", 96'(0), 96'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    resp_delay = 1;
    exp_q.delete();
    req_q.delete();
    for (int i = 0; i < 10; i++)
      push(RPC + 32'(4 * i), mem_data(RPC + 32'(4 * i)), 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_reset_outs",
        96'({imem_req_valid, idu_valid, imem_req_addr, idu_pc}),
        96'({1'b0, 1'b0, RPC, RPC}));
    for (int i = 0; i < 10; i++) begin
      wait_hs("t6_run_hs");
      if (i < 9) pulse(RPC + 32'(4 * (i + 1)));
    end

    repeat (3) @(negedge clk);
    chk("queues_empty", 96'(exp_q.size() + req_q.size()), 96'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
